mc_burst_full: RTL and testbench
================================

// Module: mc_burst_full
// PURPOSE
//  NoC-attached memory endpoint with burst reads, multiple in-flight reads and per-core completion.
//  Buffers NoC command packets in an input FIFO and issues READ/WRITE requests to the mem_req/mem_rsp port.
//  Tags each read with its requester route; returns every read beat to that requester as its own RDATA packet.
//  Raises mc_done once NUM_CORES END packets are consumed and no reads are in flight.
// PARAMETERS
//  NUM_CORES    4     END packets required before mc_done
//  ADDR_W       32    word address width (mem_address)
//  DATA_W       32    data width (mem_datain/mem_dataout)
//  SRC_W        8     requester route field width
//  LEN_W        4     burst length field; LEN=0 means 2**LEN_W beats
//  IN_DEPTH     64    input command FIFO depth, power of two
//  MAX_OUTST    8     outstanding read-tag FIFO depth, power of two
//  PKT_W  derived     2+SRC_W+ADDR_W+LEN_W+DATA_W
//    packet = {cmd[1:0], src, addr, len, data}, MSB first
//    cmd: 0 READ, 1 WRITE, 2 END, 3 RDATA
// PORTS
//  aclk            in   1      clock; all logic on rising edge
//  arst_n          in   1      asynchronous active-low reset
//  mc_start        in   1      enables dispatch; sampled, sticky
//  mc_done         out  1      completion flag, sticky
//  noc_in_valid    in   1      command word present on noc_in_data
//  noc_in_data     in   PKT_W  command packet
//  noc_in_full     out  1      input FIFO full; sender must hold
//  noc_out_valid   out  1      RDATA packet valid
//  noc_out_data    out  PKT_W  RDATA packet {3,src,addr,len,data}
//  noc_out_ready   in   1      downstream accepts noc_out_data
//  mem_req_din     out  1      push one request into memory request queue
//  mem_req_full_n  in   1      request queue not full
//  mem_req_write   out  1      1 write, 0 read
//  mem_address     out  ADDR_W request word address
//  mem_dataout     out  DATA_W write data
//  mem_size        out  32     beats; zero-extended len for reads, 1 for writes
//  mem_rsp_empty_n in   1      read data available; responses in order
//  mem_rsp_read    out  1      pop one response word
//  mem_datain      in   DATA_W read data
// BEHAVIOUR
//  Reset values: all outputs 0, except noc_in_full = 0.
//  Reset state: FIFOs empty, FSM IDLE. Reset mid-burst discards all state; there is no replay.
//  Input FIFO
//    - Writes on noc_in_valid & !full.
//    - A word offered while full is dropped; this is a sender protocol violation.
//    - Accepts words in every FSM state.
//  Dispatch FSM
//    - IDLE -> RUN the cycle after mc_start is sampled 1.
//    - RUN, head=READ:
//        issue when mem_req_full_n & tag FIFO not full;
//        drives mem_req_din=1 for exactly 1 cycle with mem_req_write=0;
//        pops the input FIFO and pushes {src,addr,len} to the tag FIFO.
//    - RUN, head=WRITE: issue when mem_req_full_n; mem_req_write=1, mem_size=1, pop.
//    - Request outputs are registered, so they appear 1 cycle after the issue decision.
//    - Back-to-back issue is allowed at one request per cycle.
//    - RUN, head=END: pop and increment end_cnt; no memory access.
//    - RUN, head=RDATA: pop and discard.
//    - RUN -> DRAIN when end_cnt==NUM_CORES.
//    - DRAIN -> DONE when the tag FIFO is empty and no return beat is pending.
//    - DONE: mc_done=1; further packets are popped and ignored.
//  Return path (1-entry output register)
//    - mem_rsp_read = mem_rsp_empty_n & (!noc_out_valid | noc_out_ready).
//    - Loads {3, tag.src, tag.addr+beat, tag.len, mem_datain}; beat counter increments.
//    - At beat==len-1 (len=0 counts as 2**LEN_W), the tag is popped and beat resets to 0.
//    - noc_out_valid holds with data stable until noc_out_ready.
//    - Simultaneous load and drain is allowed: one packet per cycle, no bubble.
//    - Address adds modulo 2**ADDR_W; wrap is silent.
//    - A response arriving with no tag is a memory fault: it is ignored and never popped.
//  Simultaneous events: a push and pop on the same FIFO in one cycle keeps the count unchanged.
// TESTING
//  1. READ src=5 addr=0x100 len=4, memory returns D0..D3
//     -> mem_size=4, one mem_req_din pulse;
//     -> 4 RDATA packets, src=5, addr 0x100..0x103, data in order.
//  2. WRITE addr=0x20 data=0xDEADBEEF
//     -> mem_req_write=1, mem_size=1, mem_dataout=0xDEADBEEF, single pulse.
//  3. Commands arrive before mc_start
//     -> no mem_req_din until 1 cycle after mc_start=1; FIFO order preserved.
//  4. Issue MAX_OUTST+1 reads with mem_rsp_empty_n=0
//     -> exactly MAX_OUTST issued;
//     -> the next issues only after the first burst's final beat is returned.
//  5. noc_out_ready low 10 cycles during a burst
//     -> mem_rsp_read=0 while the output register is full; data held, none lost.
//  6. NUM_CORES ENDs with 2 reads in flight
//     -> mc_done rises only after the last RDATA is accepted;
//     -> arst_n low clears mc_done.

Source files
------------

// File: rtl/mc_burst_full.sv
// mc_burst_full: NoC-attached memory endpoint with tagged burst
// reads, multiple reads in flight and per-core completion.
module mc_burst_full #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int SRC_W     = 8,
    parameter int LEN_W     = 4,
    parameter int IN_DEPTH  = 64,
    parameter int MAX_OUTST = 8,
    parameter int PKT_W     = 2 + SRC_W + ADDR_W + LEN_W + DATA_W
) (
    input  logic              aclk,
    input  logic              arst_n,
    input  logic              mc_start,
    output logic              mc_done,
    input  logic              noc_in_valid,
    input  logic [PKT_W-1:0]  noc_in_data,
    output logic              noc_in_full,
    output logic              noc_out_valid,
    output logic [PKT_W-1:0]  noc_out_data,
    input  logic              noc_out_ready,
    output logic              mem_req_din,
    input  logic              mem_req_full_n,
    output logic              mem_req_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_dataout,
    output logic [31:0]       mem_size,
    input  logic              mem_rsp_empty_n,
    output logic              mem_rsp_read,
    input  logic [DATA_W-1:0] mem_datain
);

    localparam int IN_AW = $clog2(IN_DEPTH);
    localparam int TG_AW = $clog2(MAX_OUTST);
    localparam int TAG_W = SRC_W + ADDR_W + LEN_W;
    localparam int END_W = $clog2(NUM_CORES + 1);

    localparam logic [1:0] CMD_RD  = 2'd0;
    localparam logic [1:0] CMD_WR  = 2'd1;
    localparam logic [1:0] CMD_END = 2'd2;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t              state_q;
    logic [END_W-1:0]    end_cnt_q;
    logic                done_q;
    logic                req_q;
    logic                wr_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   dout_q;
    logic [31:0]         size_q;

    logic [PKT_W-1:0]    in_mem_q [IN_DEPTH];
    logic [IN_AW-1:0]    in_wr_q, in_rd_q;
    logic [IN_AW:0]      in_cnt_q;
    logic                in_push, in_pop;

    logic [TAG_W-1:0]    tag_mem_q [MAX_OUTST];
    logic [TG_AW-1:0]    tag_wr_q, tag_rd_q;
    logic [TG_AW:0]      tag_cnt_q;
    logic                tag_full, tag_nempty, tag_pop;

    logic                out_vld_q;
    logic [PKT_W-1:0]    out_data_q;
    logic [LEN_W-1:0]    beat_q, beat_d;

    logic [PKT_W-1:0]    head;
    logic [1:0]          h_cmd;
    logic [SRC_W-1:0]    h_src;
    logic [ADDR_W-1:0]   h_addr;
    logic [LEN_W-1:0]    h_len;
    logic [DATA_W-1:0]   h_data;
    logic [TAG_W-1:0]    tag_head;
    logic [SRC_W-1:0]    t_src;
    logic [ADDR_W-1:0]   t_addr;
    logic [LEN_W-1:0]    t_len, len_m1;
    logic                iss_rd, iss_wr, end_inc, rsp_rd, beat_last;

    assign noc_in_full = (in_cnt_q == (IN_AW+1)'(IN_DEPTH));
    assign in_push     = noc_in_valid & ~noc_in_full;
    assign head        = in_mem_q[in_rd_q];
    assign h_cmd       = head[PKT_W-1 -: 2];
    assign h_src       = head[PKT_W-3 -: SRC_W];
    assign h_addr      = head[LEN_W+DATA_W +: ADDR_W];
    assign h_len       = head[DATA_W +: LEN_W];
    assign h_data      = head[DATA_W-1:0];

    assign tag_full    = (tag_cnt_q == (TG_AW+1)'(MAX_OUTST));
    assign tag_nempty  = (tag_cnt_q != '0);
    assign tag_head    = tag_mem_q[tag_rd_q];
    assign t_src       = tag_head[TAG_W-1 -: SRC_W];
    assign t_addr      = tag_head[LEN_W +: ADDR_W];
    assign t_len       = tag_head[LEN_W-1:0];
    assign len_m1      = t_len - 1'b1;

    // A response with no tag outstanding is never popped.
    assign rsp_rd    = mem_rsp_empty_n & tag_nempty
                     & (~out_vld_q | noc_out_ready);
    assign beat_last = (beat_q == len_m1);
    assign tag_pop   = rsp_rd & beat_last;
    assign beat_d    = beat_last ? '0 : beat_q + 1'b1;

    assign mc_done       = done_q;
    assign noc_out_valid = out_vld_q;
    assign noc_out_data  = out_data_q;
    assign mem_req_din   = req_q;
    assign mem_req_write = wr_q;
    assign mem_address   = addr_q;
    assign mem_dataout   = dout_q;
    assign mem_size      = size_q;
    assign mem_rsp_read  = rsp_rd;

    // Head-of-FIFO dispatch decision
    always_comb begin
        in_pop  = 1'b0;
        iss_rd  = 1'b0;
        iss_wr  = 1'b0;
        end_inc = 1'b0;
        if (in_cnt_q != '0) begin
            if (state_q == RUN && end_cnt_q != END_W'(NUM_CORES)) begin
                unique case (h_cmd)
                    CMD_RD: begin
                        iss_rd = mem_req_full_n & ~tag_full;
                        in_pop = iss_rd;
                    end
                    CMD_WR: begin
                        iss_wr = mem_req_full_n;
                        in_pop = iss_wr;
                    end
                    CMD_END: begin
                        end_inc = 1'b1;
                        in_pop  = 1'b1;
                    end
                    default: in_pop = 1'b1;
                endcase
            end else if (state_q == DONE) begin
                in_pop = 1'b1;
            end
        end
    end

    // FIFO storage arrays; contents are qualified by the counts
    always_ff @(posedge aclk) begin
        if (in_push) in_mem_q[in_wr_q] <= noc_in_data;
        if (iss_rd)  tag_mem_q[tag_wr_q] <= {h_src, h_addr, h_len};
    end

    // FIFO pointers and occupancy
    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            in_wr_q   <= '0;
            in_rd_q   <= '0;
            in_cnt_q  <= '0;
            tag_wr_q  <= '0;
            tag_rd_q  <= '0;
            tag_cnt_q <= '0;
        end else begin
            if (in_push) in_wr_q <= in_wr_q + 1'b1;
            if (in_pop)  in_rd_q <= in_rd_q + 1'b1;
            if (in_push & ~in_pop) in_cnt_q <= in_cnt_q + 1'b1;
            if (~in_push & in_pop) in_cnt_q <= in_cnt_q - 1'b1;
            if (iss_rd)  tag_wr_q <= tag_wr_q + 1'b1;
            if (tag_pop) tag_rd_q <= tag_rd_q + 1'b1;
            if (iss_rd & ~tag_pop) tag_cnt_q <= tag_cnt_q + 1'b1;
            if (~iss_rd & tag_pop) tag_cnt_q <= tag_cnt_q - 1'b1;
        end
    end

    // Dispatch FSM with registered request and completion outputs
    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            state_q   <= IDLE;
            end_cnt_q <= '0;
            done_q    <= 1'b0;
            req_q     <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            dout_q    <= '0;
            size_q    <= '0;
        end else begin
            req_q <= iss_rd | iss_wr;
            if (iss_rd) begin
                wr_q   <= 1'b0;
                addr_q <= h_addr;
                size_q <= 32'(h_len);
            end
            if (iss_wr) begin
                wr_q   <= 1'b1;
                addr_q <= h_addr;
                dout_q <= h_data;
                size_q <= 32'd1;
            end
            if (end_inc) end_cnt_q <= end_cnt_q + 1'b1;
            unique case (state_q)
                IDLE: if (mc_start) state_q <= RUN;
                RUN: begin
                    if (end_cnt_q == END_W'(NUM_CORES)) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (!tag_nempty && !out_vld_q) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                default: done_q <= 1'b1;
            endcase
        end
    end

    // Return path: one-entry output register, beat counter per tag
    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            beat_q     <= '0;
        end else if (rsp_rd) begin
            out_vld_q  <= 1'b1;
            out_data_q <= {2'b11, t_src, t_addr + ADDR_W'(beat_q),
                           t_len, mem_datain};
            beat_q     <= beat_d;
        end else if (noc_out_ready) begin
            out_vld_q  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_burst_full.sv
// tb_mc_burst_full: table vectors, directed corner sequences and a
// randomized run checked against a command-level reference model.
module tb_mc_burst_full;

    localparam int NUM_CORES = 4;
    localparam int PKT_W     = 2 + 8 + 32 + 4 + 32;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] size;
    } req_t;

    typedef struct {
        logic [1:0]  cmd;
        int          src;
        logic [31:0] addr;
        int          len;
        logic [31:0] data;
        int          exp_reqs;
        logic        exp_wr;
        int          exp_size;
        int          exp_beats;
    } vec_t;

    logic             aclk;
    logic             arst_n;
    logic             mc_start;
    logic             mc_done;
    logic             noc_in_valid;
    logic [PKT_W-1:0] noc_in_data;
    logic             noc_in_full;
    logic             noc_out_valid;
    logic [PKT_W-1:0] noc_out_data;
    logic             noc_out_ready;
    logic             mem_req_din;
    logic             mem_req_full_n;
    logic             mem_req_write;
    logic [31:0]      mem_address;
    logic [31:0]      mem_dataout;
    logic [31:0]      mem_size;
    logic             mem_rsp_empty_n;
    logic             mem_rsp_read;
    logic [31:0]      mem_datain;

    mc_burst_full dut (
        .aclk            (aclk),
        .arst_n          (arst_n),
        .mc_start        (mc_start),
        .mc_done         (mc_done),
        .noc_in_valid    (noc_in_valid),
        .noc_in_data     (noc_in_data),
        .noc_in_full     (noc_in_full),
        .noc_out_valid   (noc_out_valid),
        .noc_out_data    (noc_out_data),
        .noc_out_ready   (noc_out_ready),
        .mem_req_din     (mem_req_din),
        .mem_req_full_n  (mem_req_full_n),
        .mem_req_write   (mem_req_write),
        .mem_address     (mem_address),
        .mem_dataout     (mem_dataout),
        .mem_size        (mem_size),
        .mem_rsp_empty_n (mem_rsp_empty_n),
        .mem_rsp_read    (mem_rsp_read),
        .mem_datain      (mem_datain)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int n_tests, n_fail;
    int n_req, n_out, n_pops, last_req_pops, m_ends;
    logic last_wr;
    logic [31:0] last_size;
    logic hold_rsp, rdy_low, rnd_mode, prev_stall;
    logic [PKT_W-1:0] prev_data;

    req_t             exp_req[$];
    logic [PKT_W-1:0] exp_out[$];
    logic [PKT_W-1:0] tx_q[$];
    logic [31:0]      rsp_q[$];
    logic [31:0]      dev_mem[logic [31:0]];
    logic [31:0]      mdl_mem[logic [31:0]];

    function automatic void chk(string name, logic [127:0] got,
                                logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endfunction

    function automatic logic [31:0] dflt(logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    function automatic logic [31:0] dev_rd(logic [31:0] a);
        return dev_mem.exists(a) ? dev_mem[a] : dflt(a);
    endfunction

    function automatic logic [31:0] mdl_rd(logic [31:0] a);
        return mdl_mem.exists(a) ? mdl_mem[a] : dflt(a);
    endfunction

    function automatic logic [PKT_W-1:0] pkt(int cmd, int src,
        logic [31:0] addr, int len, logic [31:0] data);
        return {2'(cmd), 8'(src), addr, 4'(len), data};
    endfunction

    // Command-level model: what each accepted packet must produce.
    function automatic void model_accept(logic [PKT_W-1:0] p);
        logic [1:0]  cmd;
        logic [7:0]  src;
        logic [31:0] addr, data, a;
        logic [3:0]  len;
        int          nb;
        cmd  = p[77:76];
        src  = p[75:68];
        addr = p[67:36];
        len  = p[35:32];
        data = p[31:0];
        if (m_ends >= NUM_CORES) return;
        case (cmd)
            2'd0: begin
                nb = (len == 0) ? 16 : int'(len);
                exp_req.push_back('{1'b0, addr, 32'd0, {28'd0, len}});
                for (int i = 0; i < nb; i++) begin
                    a = addr + 32'(i);
                    exp_out.push_back({2'd3, src, a, len, mdl_rd(a)});
                end
            end
            2'd1: begin
                exp_req.push_back('{1'b1, addr, data, 32'd1});
                mdl_mem[addr] = data;
            end
            2'd2: m_ends++;
            default: ;
        endcase
    endfunction

    // One clock: drive at negedge, then observe the handshakes that
    // will complete on the following rising edge.
    task automatic step();
        req_t e;
        int   nb;
        @(negedge aclk);
        noc_in_valid = 1'b0;
        if (tx_q.size() != 0 && !noc_in_full) begin
            noc_in_valid = 1'b1;
            noc_in_data  = tx_q[0];
        end
        mem_rsp_empty_n = rsp_q.size() != 0 && !hold_rsp &&
                          (!rnd_mode || $urandom_range(0, 3) != 0);
        mem_datain = (rsp_q.size() != 0) ? rsp_q[0] : $urandom;
        noc_out_ready = !rdy_low &&
                        (!rnd_mode || $urandom_range(0, 3) != 0);
        mem_req_full_n = !rnd_mode || $urandom_range(0, 4) != 0;
        #1;
        if (noc_in_valid) model_accept(tx_q.pop_front());
        if (mem_req_din) begin
            n_req++;
            last_wr = mem_req_write;
            last_size = mem_size;
            last_req_pops = n_pops;
            chk("req_expected", exp_req.size() != 0, 1);
            if (exp_req.size() != 0) begin
                e = exp_req.pop_front();
                chk("req_wr", mem_req_write, e.wr);
                chk("req_addr", mem_address, e.addr);
                chk("req_size", mem_size, e.size);
                if (e.wr) chk("req_data", mem_dataout, e.data);
            end
            if (mem_req_write) begin
                dev_mem[mem_address] = mem_dataout;
            end else begin
                nb = (mem_size == 0) ? 16 : int'(mem_size);
                for (int i = 0; i < nb; i++)
                    rsp_q.push_back(dev_rd(mem_address + 32'(i)));
            end
        end
        if (mem_rsp_read) begin
            chk("rsp_read_ok", rsp_q.size() != 0 && mem_rsp_empty_n, 1);
            if (rsp_q.size() != 0) void'(rsp_q.pop_front());
            n_pops++;
        end
        if (noc_out_valid) begin
            if (prev_stall) chk("out_hold", noc_out_data, prev_data);
            if (!noc_out_ready) begin
                chk("stall_rsp_read", mem_rsp_read, 0);
            end else begin
                chk("out_expected", exp_out.size() != 0, 1);
                if (exp_out.size() != 0)
                    chk("out_pkt", noc_out_data, exp_out.pop_front());
                n_out++;
            end
        end
        prev_stall = noc_out_valid && !noc_out_ready;
        prev_data  = noc_out_data;
        if (mc_done) chk("done_early", exp_out.size(), 0);
    endtask

    task automatic wait_quiet(int budget);
        int k;
        k = 0;
        while ((tx_q.size() != 0 || exp_req.size() != 0 ||
                exp_out.size() != 0 || rsp_q.size() != 0) && k < budget) begin
            step();
            k++;
        end
        chk("quiet_timeout", k < budget, 1);
        repeat (3) step();
    endtask

    task automatic clear_bench();
        tx_q.delete();
        rsp_q.delete();
        exp_req.delete();
        exp_out.delete();
        dev_mem.delete();
        mdl_mem.delete();
        m_ends = 0;
        prev_stall = 1'b0;
        hold_rsp = 1'b0;
        rdy_low = 1'b0;
        rnd_mode = 1'b0;
    endtask

    task automatic check_reset_outputs();
        chk("rst_mc_done", mc_done, 0);
        chk("rst_in_full", noc_in_full, 0);
        chk("rst_out_valid", noc_out_valid, 0);
        chk("rst_out_data", noc_out_data, 0);
        chk("rst_req_din", mem_req_din, 0);
        chk("rst_req_write", mem_req_write, 0);
        chk("rst_address", mem_address, 0);
        chk("rst_dataout", mem_dataout, 0);
        chk("rst_size", mem_size, 0);
        chk("rst_rsp_read", mem_rsp_read, 0);
    endtask

    task automatic pulse_start();
        mc_start = 1'b1;
        step();
        mc_start = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        int   r0, o0, p0, r, cmd, k;
        logic [31:0] a;

        vecs[0] = '{2'd0, 5, 32'h100, 4, 32'h0, 1, 1'b0, 4, 4};
        vecs[1] = '{2'd1, 0, 32'h20, 0, 32'hDEADBEEF, 1, 1'b1, 1, 0};
        vecs[2] = '{2'd0, 9, 32'h20, 1, 32'h0, 1, 1'b0, 1, 1};
        vecs[3] = '{2'd0, 7, 32'hFFFFFFFE, 3, 32'h0, 1, 1'b0, 3, 3};
        vecs[4] = '{2'd0, 2, 32'h400, 0, 32'h0, 1, 1'b0, 0, 16};
        vecs[5] = '{2'd3, 1, 32'h50, 2, 32'h1234, 0, 1'b0, 0, 0};
        vecs[6] = '{2'd0, 3, 32'h40, 15, 32'h0, 1, 1'b0, 15, 15};

        n_tests = 0; n_fail = 0; n_req = 0; n_out = 0; n_pops = 0;
        last_req_pops = 0; last_wr = 1'b0; last_size = '0;
        prev_data = '0;
        clear_bench();
        arst_n = 1'b0; mc_start = 1'b0; noc_in_valid = 1'b0;
        noc_in_data = '0; noc_out_ready = 1'b1; mem_req_full_n = 1'b1;
        mem_rsp_empty_n = 1'b1; mem_datain = 32'hFFFFFFFF;
        repeat (2) @(negedge aclk);
        #1;
        check_reset_outputs();
        arst_n = 1'b1;

        // Commands queued before start must wait for it.
        tx_q.push_back(pkt(1, 0, 32'h30, 0, 32'hCAFE0001));
        tx_q.push_back(pkt(0, 3, 32'h30, 2, 32'h0));
        tx_q.push_back(pkt(1, 0, 32'h31, 0, 32'hCAFE0002));
        repeat (20) step();
        chk("prestart_no_req", n_req, 0);
        mc_start = 1'b1;
        step();
        mc_start = 1'b0;
        chk("start_no_early_req", n_req, 0);
        step();
        chk("start_first_req", n_req, 1);
        wait_quiet(300);
        chk("prestart_all_reqs", n_req, 3);

        for (int i = 0; i < 7; i++) begin
            r0 = n_req;
            o0 = n_out;
            tx_q.push_back(pkt(vecs[i].cmd, vecs[i].src, vecs[i].addr,
                               vecs[i].len, vecs[i].data));
            wait_quiet(500);
            chk($sformatf("vec%0d_reqs", i), n_req - r0, vecs[i].exp_reqs);
            chk($sformatf("vec%0d_beats", i), n_out - o0,
                vecs[i].exp_beats);
            if (vecs[i].exp_reqs != 0) begin
                chk($sformatf("vec%0d_wr", i), last_wr, vecs[i].exp_wr);
                chk($sformatf("vec%0d_size", i), last_size,
                    vecs[i].exp_size);
            end
        end

        // Tag FIFO exhaustion: the extra read waits for a tag to retire.
        hold_rsp = 1'b1;
        r0 = n_req;
        p0 = n_pops;
        for (int i = 0; i < 9; i++)
            tx_q.push_back(pkt(0, i, 32'h200 + 32'(16 * i), 2, 32'h0));
        repeat (40) step();
        chk("outst_cap", n_req - r0, 8);
        hold_rsp = 1'b0;
        wait_quiet(500);
        chk("outst_all", n_req - r0, 9);
        chk("outst_after_beat", (last_req_pops - p0) >= 2, 1);

        // Downstream stall in the middle of a burst.
        rdy_low = 1'b1;
        o0 = n_out;
        tx_q.push_back(pkt(0, 4, 32'h600, 8, 32'h0));
        k = 0;
        while (!noc_out_valid && k < 50) begin
            step();
            k++;
        end
        chk("stall_valid_seen", noc_out_valid, 1);
        repeat (10) step();
        rdy_low = 1'b0;
        wait_quiet(300);
        chk("stall_beats", n_out - o0, 8);

        // Completion waits for reads still in flight.
        hold_rsp = 1'b1;
        tx_q.push_back(pkt(0, 1, 32'h700, 3, 32'h0));
        tx_q.push_back(pkt(0, 2, 32'h710, 1, 32'h0));
        for (int i = 0; i < NUM_CORES; i++)
            tx_q.push_back(pkt(2, i, 32'h0, 0, 32'h0));
        repeat (30) step();
        chk("done_held", mc_done, 0);
        hold_rsp = 1'b0;
        wait_quiet(300);
        chk("done_set", mc_done, 1);
        r0 = n_req;
        tx_q.push_back(pkt(0, 6, 32'h800, 2, 32'h0));
        repeat (20) step();
        chk("done_ignores", n_req - r0, 0);
        chk("done_drains_in", noc_in_full, 0);
        chk("done_sticky", mc_done, 1);
        @(negedge aclk);
        arst_n = 1'b0;
        #1;
        chk("rst_clears_done", mc_done, 0);
        clear_bench();
        @(negedge aclk);
        #1;
        check_reset_outputs();
        arst_n = 1'b1;

        // Randomized traffic against the command-level model.
        rnd_mode = 1'b1;
        pulse_start();
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 99);
            cmd = (r < 50) ? 0 : (r < 85) ? 1 : 3;
            if ($urandom_range(0, 9) == 0)
                a = 32'hFFFFFFF8 + 32'($urandom_range(0, 7));
            else
                a = 32'($urandom_range(0, 63));
            tx_q.push_back(pkt(cmd, $urandom_range(0, 255), a,
                               $urandom_range(0, 15), $urandom));
        end
        for (int i = 0; i < NUM_CORES; i++)
            tx_q.push_back(pkt(2, i, 32'h0, 0, 32'h0));
        tx_q.push_back(pkt(0, 9, 32'h10, 3, 32'h0));
        tx_q.push_back(pkt(1, 9, 32'h11, 0, 32'h55));
        wait_quiet(20000);
        repeat (5) step();
        chk("rand_done", mc_done, 1);
        rnd_mode = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
